iob_rr_arbiter: RTL

//  Shares one IOb slave port (e.g. the output of the Wishbone-to-IOb bridge feeding the
//  MAC's register/buffer space) between N_MASTERS IOb masters (TX DMA, RX DMA, CPU).

---
 rtl/iob_rr_arbiter_pkg.sv | 13 +
 rtl/iob_rr_pick.sv | 40 ++++
 rtl/iob_rr_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/iob_rr_arbiter_pkg.sv
// Shared definitions for the IOb round-robin arbiter: FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package iob_rr_arbiter_pkg;

    // IDLE: looking for a pending slot to issue.
    // WAIT: one slave transaction outstanding, waiting for s_ready_i.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward from last+1, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides whether to consume gnt.
//
// Ports:
//   req  [N]      request vector
//   last [GNT_W]  previously granted index; scan starts just above it
//   gnt  [GNT_W]  chosen index (0 when any=0)
//   any           at least one request is set
module iob_rr_pick #(
    parameter  int N     = 2,
    localparam int GNT_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [GNT_W-1:0] last,
    output logic [GNT_W-1:0] gnt,
    output logic             any
);

    int               idx;
    logic [GNT_W-1:0] sel;

    // Offsets 1..N visit every index once, ending on 'last' itself, so a
    // lone requester that was also the previous winner is still found.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = 0;
        sel = '0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            sel = idx[GNT_W-1:0];
            if (!any && req[sel]) begin
                any = 1'b1;
                gnt = sel;
            end
        end
    end

endmodule

// File: rtl/iob_rr_arbiter.sv
// Shares one IOb slave between N_MASTERS masters; each master's 1-cycle valid is parked in a slot, issued round-robin.
// Latency: valid at cycle t -> s_valid_o at t+2; m_ready_o is combinational from s_ready_i in WAIT.
// Backpressure: one outstanding slave transaction; a second valid into an occupied slot is dropped and flagged on ovf_o.
//
// Ports:
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   m_valid_i/address/wdata/wstrb  per-master request pulse and payload (packed, master k at [k*W +: W])
//   m_rdata_o, m_ready_o        slave read data broadcast; one-hot completion to the granted master
//   s_valid_o/address/wdata/wstrb  slave request pulse; payload held for the whole transaction
//   s_rdata_i, s_ready_i        slave response
//   grant_o                     current/last granted master
//   busy_o                      transaction outstanding
//   ovf_o                       sticky per-master dropped-request flag
module iob_rr_arbiter
    import iob_rr_arbiter_pkg::*;
#(
    parameter  int N_MASTERS = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    localparam int GNT_W     = $clog2(N_MASTERS),
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [N_MASTERS-1:0]        m_valid_i,
    input  logic [N_MASTERS*ADDR_W-1:0] m_address_i,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata_i,
    input  logic [N_MASTERS*STRB_W-1:0] m_wstrb_i,
    output logic [DATA_W-1:0]           m_rdata_o,
    output logic [N_MASTERS-1:0]        m_ready_o,
    output logic                        s_valid_o,
    output logic [ADDR_W-1:0]           s_address_o,
    output logic [DATA_W-1:0]           s_wdata_o,
    output logic [STRB_W-1:0]           s_wstrb_o,
    input  logic [DATA_W-1:0]           s_rdata_i,
    input  logic                        s_ready_i,
    output logic [GNT_W-1:0]            grant_o,
    output logic                        busy_o,
    output logic [N_MASTERS-1:0]        ovf_o
);

    state_e                 state_q, state_d;
    logic                   issue;
    logic [N_MASTERS-1:0]   pending_q;
    logic [N_MASTERS-1:0]   clear;
    logic [N_MASTERS-1:0]   ovf_q;
    logic [ADDR_W-1:0]      slot_addr_q  [N_MASTERS];
    logic [DATA_W-1:0]      slot_wdata_q [N_MASTERS];
    logic [STRB_W-1:0]      slot_wstrb_q [N_MASTERS];

    logic                   s_valid_q;
    logic [ADDR_W-1:0]      s_addr_q;
    logic [DATA_W-1:0]      s_wdata_q;
    logic [STRB_W-1:0]      s_wstrb_q;
    logic [GNT_W-1:0]       grant_q;

    logic [GNT_W-1:0]       pick_gnt;
    logic                   pick_any;

    iob_rr_pick #(
        .N (N_MASTERS)
    ) u_pick (
        .req  (pending_q),
        .last (grant_q),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    // Completion is only honoured in WAIT, so a stray s_ready_i after a
    // reset (slave still finishing the old transfer) is ignored.
    always_comb begin
        clear = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            clear[k] = (state_q == ST_WAIT) && s_ready_i && (grant_q == GNT_W'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_WAIT;
                    issue   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (s_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending slots. A valid arriving in the same cycle its slot completes
    // reloads the slot instead of overflowing, so back-to-back requesters
    // never lose a request.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pending_q <= '0;
            ovf_q     <= '0;
            for (int k = 0; k < N_MASTERS; k++) begin
                slot_addr_q[k]  <= '0;
                slot_wdata_q[k] <= '0;
                slot_wstrb_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_MASTERS; k++) begin
                if (m_valid_i[k] && (!pending_q[k] || clear[k])) begin
                    pending_q[k]    <= 1'b1;
                    slot_addr_q[k]  <= m_address_i[k*ADDR_W +: ADDR_W];
                    slot_wdata_q[k] <= m_wdata_i[k*DATA_W +: DATA_W];
                    slot_wstrb_q[k] <= m_wstrb_i[k*STRB_W +: STRB_W];
                end else if (clear[k]) begin
                    pending_q[k] <= 1'b0;
                end
                if (m_valid_i[k] && pending_q[k] && !clear[k]) begin
                    ovf_q[k] <= 1'b1;
                end
            end
        end
    end

    // Slave-side registers: payload latched on issue and held until the
    // next issue, so it stays stable for the whole WAIT period.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s_valid_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
            grant_q   <= GNT_W'(N_MASTERS - 1);
        end else begin
            s_valid_q <= issue;
            if (issue) begin
                grant_q   <= pick_gnt;
                s_addr_q  <= slot_addr_q[pick_gnt];
                s_wdata_q <= slot_wdata_q[pick_gnt];
                s_wstrb_q <= slot_wstrb_q[pick_gnt];
            end
        end
    end

    assign s_valid_o   = s_valid_q;
    assign s_address_o = s_addr_q;
    assign s_wdata_o   = s_wdata_q;
    assign s_wstrb_o   = s_wstrb_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q == ST_WAIT);
    assign ovf_o       = ovf_q;
    assign m_ready_o   = clear;
    assign m_rdata_o   = s_rdata_i;

endmodule
